// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation and condition encodings, flag bit positions
// and the issue-controller state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_SUM  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_MOD  = 3'b100,
        OP_MOV  = 3'b101,
        OP_ILL6 = 3'b110,
        OP_ILL7 = 3'b111
    } op_e;

    typedef enum logic [3:0] {
        COND_EQ  = 4'b0000,
        COND_NE  = 4'b0001,
        COND_CS  = 4'b0010,
        COND_CC  = 4'b0011,
        COND_MI  = 4'b0100,
        COND_PL  = 4'b0101,
        COND_VS  = 4'b0110,
        COND_VC  = 4'b0111,
        COND_HI  = 4'b1000,
        COND_LS  = 4'b1001,
        COND_GE  = 4'b1010,
        COND_LT  = 4'b1011,
        COND_GT  = 4'b1100,
        COND_LE  = 4'b1101,
        COND_AL  = 4'b1110,
        COND_AL2 = 4'b1111
    } cond_e;

    // Flag vector layout is {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WAIT = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_MOV;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_check.sv
// Condition-code evaluation against a {N,Z,C,V} flag vector.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: latches one op, drives the ALU, waits out divider
// settling, applies conditional execution / flag update and holds the writeback.
//
// state | meaning
// IDLE  | ready for an issue
// EXEC  | latched operands on the ALU; single-cycle ops and bypassed ops capture here
// WAIT  | DIV/MOD settling, capture when the counter runs out
// WB    | writeback held until wb_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DIV_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [3:0]       in_cond,
    input  logic             in_flag_we,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_rd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       wb_rd,
    output logic             wb_exec,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             illegal
);

    localparam logic [3:0] DIV_LOAD = 4'(DIV_LATENCY - 1);

    generate
        if (DIV_LATENCY < 1 || DIV_LATENCY > 15) begin : g_bad_latency
            $error("DIV_LATENCY must be in 1..15");
        end
    endgenerate

    state_e           state;
    state_e           state_nxt;

    logic [2:0]       op_q;
    logic [3:0]       cond_q;
    logic             fwe_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       rd_q;
    logic [3:0]       cnt_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] wb_data_q;
    logic             wb_exec_q;
    logic             illegal_q;

    logic             accept;
    logic             legal;
    logic             is_div;
    logic             div_zero;
    logic             bypass;
    logic             wait_needed;
    logic             capture;
    logic             pass;

    cond_check u_cond_check (
        .cond  (cond_q),
        .flags (flags_q),
        .pass  (pass)
    );

    assign accept      = in_valid && (state == ST_IDLE);
    assign legal       = op_legal(op_q);
    assign is_div      = op_is_div(op_q);
    assign div_zero    = is_div && (b_q == '0);
    // Illegal ops and divide-by-zero skip the settle wait and write back zero
    assign bypass      = !legal || div_zero;
    assign wait_needed = is_div && !bypass && (DIV_LATENCY > 1);
    assign capture     = ((state == ST_EXEC) && !wait_needed) ||
                         ((state == ST_WAIT) && (cnt_q == 4'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = wait_needed ? ST_WAIT : ST_WB;
            ST_WAIT: if (cnt_q == 4'd1) state_nxt = ST_WB;
            ST_WB:   if (wb_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        wb_valid = (state == ST_WB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            cond_q    <= '0;
            fwe_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            flags_q   <= '0;
            wb_data_q <= '0;
            wb_exec_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= in_op;
                cond_q <= in_cond;
                fwe_q  <= in_flag_we;
                a_q    <= in_a;
                b_q    <= in_b;
                rd_q   <= in_rd;
            end

            if (state == ST_EXEC) begin
                cnt_q <= DIV_LOAD;
            end else if (state == ST_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end

            // Capture is the only point where the flag register can change
            illegal_q <= capture && !legal;
            if (capture) begin
                wb_data_q <= bypass ? '0 : alu_result;
                wb_exec_q <= pass && !bypass;
                if (pass && fwe_q && !bypass) begin
                    flags_q <= alu_flags;
                end
            end
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = op_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = rd_q;
    assign wb_exec  = wb_exec_q;
    assign flags    = flags_q;
    assign illegal  = illegal_q;

endmodule
